// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and index-width helper for the digit-serial BCD adder.
// Latency: none (package only).
// Backpressure: not applicable.
package bcd_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-digit build still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result handshake bundle for bcd_serial_adder; sub exists only with BCD_SUB_EN.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on operands, out_valid/out_ready on the result.
interface bcd_serial_adder_if #(
    parameter int NDIGITS = 4
);
    localparam int W = bcd_pkg::DIGIT_W * NDIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef BCD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    modport master (
`ifdef BCD_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, err
    );

    modport slave (
`ifdef BCD_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with decimal correction: digit + carry out.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               i_cin,
    output logic [DIGIT_W-1:0] o_d,
    output logic               o_cout
);
    localparam logic [DIGIT_W:0] MAX5  = BCD_MAX[DIGIT_W:0];
    localparam logic [DIGIT_W:0] CORR5 = BCD_CORR[DIGIT_W:0];

    logic [DIGIT_W:0] w_s5;
    logic [DIGIT_W:0] w_corr;

    always_comb begin
        w_s5   = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_cin};
        w_corr = w_s5 + CORR5;
        o_d    = w_s5[DIGIT_W-1:0];
        o_cout = 1'b0;
        if (w_s5 > MAX5) begin
            o_d    = w_corr[DIGIT_W-1:0];
            o_cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder (LSD first, one shared digit adder); BCD_SUB_EN adds ten's-complement A-B.
// Latency: out_valid rises NDIGITS edges after the accepting edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    bcd_serial_adder_if.slave  bus
);
    localparam int W  = DIGIT_W * NDIGITS;
    localparam int IW = idx_width(NDIGITS);
    localparam logic [IW-1:0]      LAST = IW'(NDIGITS - 1);
    localparam logic [DIGIT_W-1:0] MAXD = DIGIT_W'(BCD_MAX);

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_err;
    logic [IW-1:0]      r_idx;
    logic [DIGIT_W-1:0] w_bdig;
    logic [DIGIT_W-1:0] w_d;
    logic               w_c;
    logic               w_bad;
    logic               w_accept;
    logic               w_in_ready;
    logic               w_out_valid;
`ifdef BCD_SUB_EN
    logic               r_sub;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = ST_RUN;
            end
            ST_RUN:  if (r_idx == LAST) w_next = ST_DONE;
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept = w_in_ready && bus.in_valid;

    // The nines' complement is taken on the fly, so err still sees the raw B digit.
`ifdef BCD_SUB_EN
    assign w_bdig = r_sub ? (MAXD - r_b[DIGIT_W-1:0]) : r_b[DIGIT_W-1:0];
`else
    assign w_bdig = r_b[DIGIT_W-1:0];
`endif
    assign w_bad = (r_a[DIGIT_W-1:0] > MAXD) || (r_b[DIGIT_W-1:0] > MAXD);

    bcd_digit_add u_digit (
        .i_a    (r_a[DIGIT_W-1:0]),
        .i_b    (w_bdig),
        .i_cin  (r_carry),
        .o_d    (w_d),
        .o_cout (w_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
`ifdef BCD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sum   <= '0;
            r_err   <= 1'b0;
            r_idx   <= '0;
`ifdef BCD_SUB_EN
            r_sub   <= bus.sub;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
`else
            r_carry <= bus.cin;
`endif
        end else if (r_state == ST_RUN) begin
            // Result digits enter at the top so digit 0 lands at the bottom after NDIGITS shifts.
            r_a     <= r_a >> DIGIT_W;
            r_b     <= r_b >> DIGIT_W;
            r_sum   <= (r_sum >> DIGIT_W) | (W'(w_d) << (W - DIGIT_W));
            r_carry <= w_c;
            r_err   <= r_err | w_bad;
            r_idx   <= r_idx + IW'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
    assign bus.err       = r_err;

endmodule
